alu_result_latch: RTL and testbench

Registered output stage directly downstream of the 8-bit ALU. It captures the ALU result and flags on command and derives the zero flag, which the ALU does not produce. It holds the captured values for the control unit and, on request, arbitrates for the shared 8-bit databus and drives the result onto it one byte per cycle.

---
 rtl/alu_result_latch.sv | 139 +++++++++++++
 tb/tb_alu_result_latch.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_latch.sv
// Output register stage behind the 8-bit ALU: captures result/flags, derives the zero flag,
// and transfers the held result onto the shared databus one byte per cycle after arbitration.
module alu_result_latch #(
    parameter int GRANT_TIMEOUT = 15
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] alu_out,
    input  logic [3:0]  alu_flags,
    input  logic        latch,
    input  logic        wide,
    input  logic        rd_req,
    input  logic        bus_grant,
    output logic        bus_req,
    output logic        bus_oe,
    output logic [7:0]  bus_data,
    output logic [15:0] result,
    output logic [3:0]  flags,
    output logic        busy,
    output logic        done,
    output logic        timeout,
    output logic        overrun
);

    localparam logic [7:0] TMO_LAST = 8'(GRANT_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HOLD,
        S_REQ,
        S_DRV_LO,
        S_DRV_HI
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_wide;
    logic [7:0]  r_cnt;
    logic [15:0] r_result;
    logic [3:0]  r_flags;
    logic        r_done;
    logic        r_timeout;
    logic        r_overrun;

    logic        w_busy;
    logic        w_capture;
    logic        w_tmo;
    logic        w_zero;
    logic        w_unused;

    // Flag bits 1 and 3 from the ALU carry no meaning here.
    assign w_unused  = ^{alu_flags[3], alu_flags[1]};

    assign w_busy    = (r_state == S_REQ) || (r_state == S_DRV_LO) || (r_state == S_DRV_HI);
    assign w_capture = latch && ((r_state == S_IDLE) || (r_state == S_HOLD));
    assign w_tmo     = (r_state == S_REQ) && !bus_grant && (r_cnt == TMO_LAST);
    assign w_zero    = wide ? (alu_out == 16'h0000) : (alu_out[7:0] == 8'h00);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (latch) w_next = S_HOLD;
            S_HOLD:   if (rd_req) w_next = S_REQ;
            // A grant on the last counted cycle still wins over the timeout.
            S_REQ: begin
                if (bus_grant)  w_next = S_DRV_LO;
                else if (w_tmo) w_next = S_HOLD;
            end
            S_DRV_LO: w_next = r_wide ? S_DRV_HI : S_HOLD;
            S_DRV_HI: w_next = S_HOLD;
            default:  w_next = S_IDLE;
        endcase
    end

    // Bus outputs decode only the state register so they cannot glitch on inputs.
    always_comb begin
        bus_req  = w_busy;
        busy     = w_busy;
        bus_oe   = 1'b0;
        bus_data = 8'h00;
        case (r_state)
            S_DRV_LO: begin
                bus_oe   = 1'b1;
                bus_data = r_result[7:0];
            end
            S_DRV_HI: begin
                bus_oe   = 1'b1;
                bus_data = r_result[15:8];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_result <= 16'h0000;
            r_flags  <= 4'h0;
            r_wide   <= 1'b0;
        end else if (w_capture) begin
            r_result <= wide ? alu_out : {8'h00, alu_out[7:0]};
            r_flags  <= {1'b0, alu_flags[2], w_zero, alu_flags[0]};
            r_wide   <= wide;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt <= 8'h00;
        end else if (r_state == S_HOLD && rd_req) begin
            r_cnt <= 8'h00;
        end else if (r_state == S_REQ && !bus_grant && !w_tmo) begin
            r_cnt <= r_cnt + 8'h01;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_done    <= (r_state == S_DRV_HI) || (r_state == S_DRV_LO && !r_wide);
            r_timeout <= w_tmo;
            r_overrun <= latch && w_busy;
        end
    end

    assign result  = r_result;
    assign flags   = r_flags;
    assign done    = r_done;
    assign timeout = r_timeout;
    assign overrun = r_overrun;

endmodule

// File: tb/tb_alu_result_latch.sv
// Scoreboard bench for alu_result_latch: stimulus queues expected bus bytes and pulses,
// an independent negedge monitor pops and compares them as the DUT produces them.
module tb_alu_result_latch;

    localparam int GT = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] alu_out = 16'h0000;
    logic [3:0]  alu_flags = 4'h0;
    logic        latch = 1'b0;
    logic        wide = 1'b0;
    logic        rd_req = 1'b0;
    logic        bus_grant = 1'b0;
    logic        bus_req, bus_oe, busy, done, timeout, overrun;
    logic [7:0]  bus_data;
    logic [15:0] result;
    logic [3:0]  flags;

    alu_result_latch #(.GRANT_TIMEOUT(GT)) dut (
        .clock(clock), .reset(reset), .alu_out(alu_out), .alu_flags(alu_flags),
        .latch(latch), .wide(wide), .rd_req(rd_req), .bus_grant(bus_grant),
        .bus_req(bus_req), .bus_oe(bus_oe), .bus_data(bus_data), .result(result),
        .flags(flags), .busy(busy), .done(done), .timeout(timeout), .overrun(overrun)
    );

    always #5 clock = ~clock;

    typedef enum logic [1:0] {K_BYTE, K_DONE, K_TMO, K_OVR} kind_t;
    typedef struct {
        kind_t      kind;
        logic [7:0] data;
    } ev_t;

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input kind_t k, input logic [7:0] d);
        ev_t e;
        e.kind = k;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic mon(input kind_t k, input logic [7:0] d, input string name);
        ev_t e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected %s: got data %h, expected nothing at %0t", name, d, $time);
        end else begin
            e = exp_q.pop_front();
            if (e.kind !== k || e.data !== d) begin
                n_fail++;
                $display("FAIL %s: got kind %0d data %h expected kind %0d data %h at %0t",
                         name, k, d, e.kind, e.data, $time);
            end
        end
    endtask

    // Monitor: events are checked in a fixed per-cycle order byte, done, timeout, overrun.
    always @(negedge clock) begin
        if (bus_oe) mon(K_BYTE, bus_data, "bus byte");
        else        chk("bus_data idle", {8'h00, bus_data}, 16'h0000);
        if (done)    mon(K_DONE, 8'h00, "done");
        if (timeout) mon(K_TMO,  8'h00, "timeout");
        if (overrun) mon(K_OVR,  8'h00, "overrun");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic capture(input logic [15:0] a, input logic [3:0] f, input logic w);
        alu_out = a; alu_flags = f; wide = w; latch = 1'b1;
        tick();
        latch = 1'b0;
    endtask

    // Issue rd_req, hold grant low for d REQ cycles, then grant for one cycle.
    task automatic read(input int d);
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        chk("bus_req in REQ", {15'h0, bus_req}, 16'h1);
        repeat (d) tick();
        bus_grant = 1'b1;
        tick();
        bus_grant = 1'b0;
        repeat (3) tick();
    endtask

    initial begin
        int cnt;
        repeat (2) tick();
        reset = 1'b0;
        chk("reset result", result, 16'h0000);
        chk("reset flags", {12'h0, flags}, 16'h0);
        chk("reset bus_req", {15'h0, bus_req}, 16'h0);
        chk("reset bus_oe", {15'h0, bus_oe}, 16'h0);
        chk("reset busy", {15'h0, busy}, 16'h0);
        chk("reset pulses", {13'h0, done, timeout, overrun}, 16'h0);

        // rd_req alone in IDLE does nothing
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        chk("idle rd_req bus_req", {15'h0, bus_req}, 16'h0);
        tick();
        chk("idle rd_req busy", {15'h0, busy}, 16'h0);

        // narrow capture and transfer
        capture(16'h0180, 4'b0101, 1'b0);
        chk("narrow result", result, 16'h0080);
        chk("narrow flags", {12'h0, flags}, 16'h0005);
        push(K_BYTE, 8'h80); push(K_DONE, 8'h00);
        read(2);

        // zero flag
        capture(16'h0100, 4'b0000, 1'b0);
        chk("zero narrow result", result, 16'h0000);
        chk("zero narrow flags", {12'h0, flags}, 16'h0002);
        capture(16'h0100, 4'b0001, 1'b1);
        chk("zero wide result", result, 16'h0100);
        chk("zero wide flags", {12'h0, flags}, 16'h0001);

        // wide transfer
        capture(16'h1234, 4'b0100, 1'b1);
        chk("wide flags", {12'h0, flags}, 16'h0004);
        push(K_BYTE, 8'h34); push(K_BYTE, 8'h12); push(K_DONE, 8'h00);
        read(0);

        // timeout with grant held low
        push(K_TMO, 8'h00);
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        cnt = 0;
        repeat (8) begin
            if (bus_req) cnt++;
            tick();
        end
        chk("timeout req cycles", 16'(cnt), 16'(GT));
        chk("timeout result kept", result, 16'h1234);
        chk("timeout busy", {15'h0, busy}, 16'h0);

        // grant in the final counted cycle beats the timeout
        push(K_BYTE, 8'h34); push(K_BYTE, 8'h12); push(K_DONE, 8'h00);
        read(GT - 1);

        // overrun during DRV_LO
        capture(16'h0055, 4'b0000, 1'b0);
        push(K_BYTE, 8'h55); push(K_DONE, 8'h00); push(K_OVR, 8'h00);
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0; bus_grant = 1'b1;
        tick();
        bus_grant = 1'b0; alu_out = 16'h00EE; latch = 1'b1;
        tick();
        latch = 1'b0;
        chk("overrun result kept", result, 16'h0055);
        repeat (2) tick();
        chk("overrun result later", result, 16'h0055);

        // same-cycle latch + rd_req in HOLD
        alu_out = 16'h00AA; alu_flags = 4'h0; wide = 1'b0; latch = 1'b1; rd_req = 1'b1;
        push(K_BYTE, 8'hAA); push(K_DONE, 8'h00);
        tick();
        latch = 1'b0; rd_req = 1'b0; bus_grant = 1'b1;
        tick();
        bus_grant = 1'b0;
        repeat (3) tick();
        chk("same-cycle result", result, 16'h00AA);

        // reset asserted mid-DRV_HI
        capture(16'h1234, 4'b0000, 1'b1);
        push(K_BYTE, 8'h34); push(K_BYTE, 8'h12);
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0; bus_grant = 1'b1;
        tick();
        bus_grant = 1'b0;
        tick();
        chk("drv_hi bus_oe", {15'h0, bus_oe}, 16'h1);
        @(negedge clock);
        #1 reset = 1'b1;
        #1;
        chk("async reset bus_oe", {15'h0, bus_oe}, 16'h0);
        chk("async reset bus_req", {15'h0, bus_req}, 16'h0);
        chk("async reset result", result, 16'h0000);
        chk("async reset flags", {12'h0, flags}, 16'h0);
        repeat (2) tick();
        reset = 1'b0;
        chk("post reset busy", {15'h0, busy}, 16'h0);
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        chk("post reset idle rd_req", {15'h0, bus_req}, 16'h0);
        repeat (3) tick();
        chk("scoreboard drained", 16'(exp_q.size()), 16'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
